// File: rtl/csa_pkg.sv
// Shared encodings and default geometry for the sequential carry-select adder.
package csa_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int WidthDefault = 32;
    localparam int BlockDefault = 8;

endpackage

// File: rtl/csa_block.sv
// One carry-select slice: computes both carry-in hypotheses and picks one by carry_i.
module csa_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             carry_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             c_o
);

    localparam logic [BLOCK:0] One = {{BLOCK{1'b0}}, 1'b1};

    logic [BLOCK-1:0] sum0, sum1;
    logic             c0, c1;

    assign {c0, sum0} = {1'b0, a_i} + {1'b0, b_i};
    assign {c1, sum1} = {1'b0, a_i} + {1'b0, b_i} + One;

    mux2to1 #(
        .WIDTH(BLOCK)
    ) u_sum_mux (
        .d0_i (sum0),
        .d1_i (sum1),
        .sel_i(carry_i),
        .y_o  (sum_o)
    );

    mux2to1 #(
        .WIDTH(1)
    ) u_carry_mux (
        .d0_i (c0),
        .d1_i (c1),
        .sel_i(carry_i),
        .y_o  (c_o)
    );

endmodule

// File: rtl/mux2to1.sv
// Two-input multiplexer; d1_i is selected when sel_i is high.
module mux2to1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/csa_seq_adder.sv
// Sequential adder: one csa_block slice reused over NBLK cycles, ripple carry held in carry_q.
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = WidthDefault,
    parameter int BLOCK = BlockDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NBLK = (BLOCK > 0) ? (WIDTH / BLOCK) : 1;
    localparam int IdxW = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBLK - 1);

    if (BLOCK < 1) begin : g_bad_block
        $error("csa_seq_adder: BLOCK must be at least 1");
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
        $error("csa_seq_adder: WIDTH must be a multiple of BLOCK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [BLOCK-1:0] blk_a, blk_b, blk_sum;
    logic             blk_carry;

    assign blk_a = a_q[int'(idx_q) * BLOCK +: BLOCK];
    assign blk_b = b_q[int'(idx_q) * BLOCK +: BLOCK];

    csa_block #(
        .BLOCK(BLOCK)
    ) u_block (
        .a_i    (blk_a),
        .b_i    (blk_b),
        .carry_i(carry_q),
        .sum_o  (blk_sum),
        .c_o    (blk_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[int'(idx_q) * BLOCK +: BLOCK] = blk_sum;
                carry_d = blk_carry;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    cout_d  = blk_carry;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Gated by rst so nothing is offered during a reset cycle.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
